// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial link: frame size and deserializer FSM states.
// The PISO side imports this too, so both ends agree on the frame width.
package sipo_deserializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle: qualified serial bits in, valid/ready word out,
// plus overrun status/clear and frame-in-progress indication.
interface sipo_deserializer_if
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             sin;
  logic             sin_valid;
  logic             sin_sof;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             overrun;
  logic             clr_overrun;
  logic             busy;

  modport master (
    output sin, sin_valid, sin_sof, pout_ready, clr_overrun,
    input  pout, pout_valid, overrun, busy
  );

  modport slave (
    input  sin, sin_valid, sin_sof, pout_ready, clr_overrun,
    output pout, pout_valid, overrun, busy
  );

endinterface

// File: rtl/sipo_deserializer_out_buf.sv
// One-entry valid/ready holding register for completed words, with sticky overrun
// when a word completes while the previous one is still unconsumed.
module sipo_out_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
  input  logic             pout_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             overrun
);

  logic load_c;
  logic drop_c;

  // Load when empty or when the held word is consumed on this same edge.
  assign load_c = word_done & (~pout_valid | pout_ready);
  assign drop_c = word_done & pout_valid & ~pout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_c) begin
        pout       <= word;
        pout_valid <= 1'b1;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
      // Setting wins over a simultaneous clear.
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Rebuilds WIDTH-bit words from a qualified serial stream aligned on start-of-frame,
// handing each completed word to a one-entry output buffer.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  sipo_deserializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             busy_q;

  logic [WIDTH-1:0] shift_c;
  logic [WIDTH-1:0] first_c;
  logic             done_c;

  // First bit of a frame sits where later bits will push it to its final position.
  assign shift_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.sin}
                             : {bus.sin, shreg_q[WIDTH-1:1]};
  assign first_c = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.sin}
                             : {bus.sin, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      busy_q  <= (state_d == SHIFT);
    end
  end

  // Completion outranks sof on the last bit; sof mid-frame silently restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.sin_sof) begin
          shreg_d = first_c;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          if (cnt_q == LAST_CNT) begin
            done_c  = 1'b1;
            shreg_d = shift_c;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (bus.sin_sof) begin
            shreg_d = first_c;
            cnt_d   = CNT_W'(1);
          end else begin
            shreg_d = shift_c;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;

  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_done   (done_c),
    .word        (shift_c),
    .pout_ready  (bus.pout_ready),
    .clr_overrun (bus.clr_overrun),
    .pout        (bus.pout),
    .pout_valid  (bus.pout_valid),
    .overrun     (bus.overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=4, MSB first): inputs change and
// outputs are sampled on the falling edge.
module tb_sipo_deserializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sipo_deserializer_if #(.WIDTH(4)) bus ();

  sipo_deserializer #(
    .WIDTH     (4),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the falling edge, then present one cycle of serial input.
  task automatic step(input logic v, input logic b, input logic s);
    @(negedge clk);
    bus.sin_valid = v;
    bus.sin       = b;
    bus.sin_sof   = s;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [3:0] w);
    step(1'b1, w[3], 1'b1);
    step(1'b1, w[2], 1'b0);
    step(1'b1, w[1], 1'b0);
    step(1'b1, w[0], 1'b0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.sin         = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.sin_sof     = 1'b0;
    bus.pout_ready  = 1'b1;
    bus.clr_overrun = 1'b0;

    #3;
    check("rst_pout", 32'(bus.pout), 32'h0);
    check("rst_valid", 32'(bus.pout_valid), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    #14 rst_n = 1'b1;

    // Basic frame 1011 with ready held high.
    frame(4'b1011);
    check("basic_busy_mid", 32'(bus.busy), 32'h1);
    check("basic_valid_early", 32'(bus.pout_valid), 32'h0);
    idle();
    check("basic_valid", 32'(bus.pout_valid), 32'h1);
    check("basic_pout", 32'(bus.pout), 32'hb);
    check("basic_busy_done", 32'(bus.busy), 32'h0);
    idle();
    check("basic_valid_1cyc", 32'(bus.pout_valid), 32'h0);

    // Three idle cycles between bits 2 and 3.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("gap_busy", 32'(bus.busy), 32'h1);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle();
    check("gap_pout", 32'(bus.pout), 32'hb);
    check("gap_valid", 32'(bus.pout_valid), 32'h1);
    idle();

    // Bits without sof while idle are discarded.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle();
    check("nosof_busy", 32'(bus.busy), 32'h0);
    check("nosof_valid", 32'(bus.pout_valid), 32'h0);

    // Partial frame 1,1 then resync on sof with 0110.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    frame(4'b0110);
    idle();
    check("resync_pout", 32'(bus.pout), 32'h6);
    check("resync_valid", 32'(bus.pout_valid), 32'h1);
    check("resync_overrun", 32'(bus.overrun), 32'h0);
    idle();

    // sof on the last bit is ignored: frame completes as 1101.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle();
    check("lastsof_pout", 32'(bus.pout), 32'hd);
    check("lastsof_busy", 32'(bus.busy), 32'h0);
    idle();

    // Backpressure: second word is dropped and overrun set.
    bus.pout_ready = 1'b0;
    frame(4'b1011);
    idle();
    check("bp_pout1", 32'(bus.pout), 32'hb);
    check("bp_overrun0", 32'(bus.overrun), 32'h0);
    frame(4'b0101);
    idle();
    check("bp_pout_kept", 32'(bus.pout), 32'hb);
    check("bp_valid", 32'(bus.pout_valid), 32'h1);
    check("bp_overrun", 32'(bus.overrun), 32'h1);
    idle();
    bus.clr_overrun = 1'b1;
    idle();
    bus.clr_overrun = 1'b0;
    check("clr_overrun", 32'(bus.overrun), 32'h0);
    check("clr_pout", 32'(bus.pout), 32'hb);

    // Back-to-back: 0110 completes on the same edge that 1011 is accepted.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    bus.pout_ready = 1'b1;
    idle();
    bus.pout_ready = 1'b0;
    check("b2b_pout", 32'(bus.pout), 32'h6);
    check("b2b_valid", 32'(bus.pout_valid), 32'h1);
    check("b2b_overrun", 32'(bus.overrun), 32'h0);
    bus.pout_ready = 1'b1;
    idle();
    check("b2b_drain", 32'(bus.pout_valid), 32'h0);

    // Asynchronous reset mid-frame, then a clean frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle();
    check("mid_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pout", 32'(bus.pout), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_valid", 32'(bus.pout_valid), 32'h0);
    #1 rst_n = 1'b1;
    frame(4'b1001);
    idle();
    check("post_rst_pout", 32'(bus.pout), 32'h9);
    check("post_rst_valid", 32'(bus.pout_valid), 32'h1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Downstream consumer of the serial stream produced by the 4-bit parallel-load shift register (PISO).
- Rebuilds WIDTH-bit parallel words from a qualified serial bit stream, using a start-of-frame marker to align.
- Presents each complete word on a valid/ready output with a one-word holding register and a sticky overrun flag.
- Sits between the serial link and the parallel consumer logic.

Parameters:
- WIDTH, 4: bits per frame; must be ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in pout[WIDTH-1]; 0 = first bit lands in pout[0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is a valid bit this cycle.
- sin_sof  input  1  start of frame; qualified by sin_valid; marks the current bit as bit 0 of a frame.
- pout  output  WIDTH  assembled word; stable while pout_valid=1.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout this cycle when pout_valid=1.
- overrun  output  1  sticky; a completed word was dropped.
- clr_overrun  input  1  synchronous clear of overrun.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, bit counter=0, shift register=0, pout=0, pout_valid=0, overrun=0, busy=0.
- States: IDLE and SHIFT.
- IDLE:
  - sin_valid & sin_sof: store sin as bit 0, set counter=1, go to SHIFT.
  - sin_valid without sof: bit is discarded.
  - No sin_valid: nothing happens.
- SHIFT:
  - Each sin_valid bit is shifted in and the counter increments.
  - Bits enter at the LSB and move toward the MSB when MSB_FIRST=1; mirrored when MSB_FIRST=0.
  - Cycles without sin_valid hold all state; there is no timeout.
- Resync: sin_valid & sin_sof in SHIFT aborts the partial frame without flagging it. That bit becomes bit 0 and the counter becomes 1.
- Completion: when sin_valid arrives with counter=WIDTH-1, the word is complete.
  - Completion takes priority over sin_sof on the same bit; the sof on a last bit is ignored.
  - State returns to IDLE and the counter returns to 0.
- Output load:
  - A complete word loads pout on the same edge that samples the last bit. pout_valid=1 from the next cycle, i.e. latency 1 clk after the last bit edge.
  - Load condition: pout_valid=0, or pout_ready=1 in that cycle.
  - Simultaneous completion and acceptance: the old word is consumed and the new word is loaded; pout_valid stays 1 with no bubble.
- Drop: completion while pout_valid=1 and pout_ready=0.
  - New word is discarded; pout is unchanged.
  - overrun is set on that edge.
- Handshake: pout_valid falls on the edge where pout_valid & pout_ready and no new word loads. pout_ready while pout_valid=0 has no effect.
- overrun:
  - Cleared by clr_overrun.
  - Set has priority over clear in the same cycle.
- busy = (state==SHIFT), registered.
- Reset mid-frame: partial frame is lost and outputs go to reset values immediately (asynchronous).
- Width rules:
  - Counter width is $clog2(WIDTH).
  - The counter never exceeds WIDTH-1; there is no wrap-around beyond completion.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and the default WIDTH constant. The package is shared with the PISO side so both ends agree on frame size.
- Natural split:
  - Sub-module sipo_out_buf holds the one-entry valid/ready holding register and overrun logic.
  - The top holds the FSM, counter and shift register.

Test Plan:
- Basic (WIDTH=4, MSB_FIRST=1): bits 1,0,1,1 on consecutive cycles, sof on the first bit, pout_ready=1 → pout=4'b1011, pout_valid=1 for exactly 1 cycle, 1 clk after the 4th bit edge.
- Gaps: same frame with sin_valid low for 3 cycles between bits 2 and 3 → pout=4'b1011, busy high throughout the gap.
- No sof / resync:
  - Bits without sof in IDLE → ignored.
  - Frame 1,1 then sof+0,1,1,0 → pout=4'b0110, overrun=0.
- Backpressure:
  - pout_ready=0; frames 1011 then 0101 → pout stays 1011, overrun=1 after the 2nd frame.
  - clr_overrun pulse → overrun=0.
- Back-to-back: pout_valid=1 with 1011, next frame 0110 completes in the same cycle as pout_ready=1 → pout=0110, pout_valid stays 1.
- Reset: rst_n low after 2 bits of a frame → all outputs 0 immediately, with no clk edge required. After release, a full frame 1001 → pout=4'b1001.
